// File: rtl/cache_stats_counter_if.sv
// rtl/cache_stats_counter_if.sv - Access strobes, dump control and record stream of the cache statistics counter
interface cache_stats_counter_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32
);
   localparam int CH_W = $clog2(NUM_CH + 1);

   logic [NUM_CH-1:0] acc_valid;
   logic [NUM_CH-1:0] acc_write;
   logic [NUM_CH-1:0] acc_hit;
   logic              clear;
   logic              dump_req;
   logic              dump_busy;
   logic              out_valid;
   logic              out_ready;
   logic [CH_W-1:0]   out_ch;
   logic [1:0]        out_sel;
   logic [CNT_W-1:0]  out_data;
   logic              out_last;

   modport master (
      output acc_valid, acc_write, acc_hit, clear, dump_req, out_ready,
      input  dump_busy, out_valid, out_ch, out_sel, out_data, out_last
   );

   modport slave (
      input  acc_valid, acc_write, acc_hit, clear, dump_req, out_ready,
      output dump_busy, out_valid, out_ch, out_sel, out_data, out_last
   );
endinterface

// File: rtl/cache_stats_counter.sv
// rtl/cache_stats_counter.sv - Per-channel read/write/hit/miss counters with snapshot dump as a record stream
module cache_stats_counter #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32
) (
   input  logic clk,
   input  logic rst,
   cache_stats_counter_if.slave bus
);
   localparam int              CH_W    = $clog2(NUM_CH + 1);
   localparam int              SUM_W   = CNT_W + 4;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt  [NUM_CH][4];
   logic [CNT_W-1:0]  r_snap [NUM_CH][4];
   logic [CH_W-1:0]   r_ch;
   logic [1:0]        r_sel;
   logic              w_start;
   logic              w_xfer;
   logic              w_last;
   logic [SUM_W-1:0]  w_sum;
   logic [CNT_W-1:0]  w_total;
   logic [CNT_W-1:0]  w_ch_data;
   logic [CNT_W-1:0]  w_data;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + CNT_W'(1);
   endfunction

   assign w_start = (r_state == IDLE) && bus.dump_req;
   assign w_xfer  = (r_state == SEND) && bus.out_ready;
   assign w_last  = (r_ch == LAST_CH) && (r_sel == 2'd3);

   // Counter index: 0 reads, 1 writes, 2 hits, 3 misses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < 4; s++)
               r_cnt[c][s] <= '0;
      end else if (bus.clear) begin
         for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < 4; s++)
               r_cnt[c][s] <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.acc_valid[c]) begin
               if (bus.acc_write[c]) r_cnt[c][1] <= sat_inc(r_cnt[c][1]);
               else                  r_cnt[c][0] <= sat_inc(r_cnt[c][0]);
               if (bus.acc_hit[c])   r_cnt[c][2] <= sat_inc(r_cnt[c][2]);
               else                  r_cnt[c][3] <= sat_inc(r_cnt[c][3]);
            end
         end
      end
   end

   // Snapshot captures pre-edge live values, so same-cycle events and clear do not leak in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < 4; s++)
               r_snap[c][s] <= '0;
         r_ch  <= '0;
         r_sel <= '0;
      end else if (w_start) begin
         for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < 4; s++)
               r_snap[c][s] <= r_cnt[c][s];
         r_ch  <= '0;
         r_sel <= '0;
      end else if (w_xfer) begin
         if (w_last) begin
            r_ch  <= '0;
            r_sel <= '0;
         end else if (r_sel == 2'd3) begin
            r_sel <= '0;
            r_ch  <= r_ch + CH_W'(1);
         end else begin
            r_sel <= r_sel + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.dump_req) w_next = SEND;
         SEND:    if (w_xfer && w_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_sum     = '0;
      w_ch_data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_sum = w_sum + SUM_W'(r_snap[c][r_sel]);
         if (r_ch == CH_W'(c)) w_ch_data = r_snap[c][r_sel];
      end
      w_total = (|w_sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
      w_data  = (r_ch == LAST_CH) ? w_total : w_ch_data;
   end

   always_comb begin
      bus.dump_busy = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_ch    = '0;
      bus.out_sel   = '0;
      bus.out_data  = '0;
      bus.out_last  = 1'b0;
      if (r_state == SEND) begin
         bus.dump_busy = 1'b1;
         bus.out_valid = 1'b1;
         bus.out_ch    = r_ch;
         bus.out_sel   = r_sel;
         bus.out_data  = w_data;
         bus.out_last  = w_last;
      end
   end
endmodule

// File: tb/tb_cache_stats_counter.sv
// tb/tb_cache_stats_counter.sv - Self-checking bench for cache_stats_counter
module tb_cache_stats_counter;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;
   localparam int NREC   = 4 * (NUM_CH + 1);
   localparam int MAXV   = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [1:0]       ch;
      logic [1:0]       sel;
      logic [CNT_W-1:0] data;
      logic             last;
   } rec_t;

   typedef struct {
      logic [1:0] v;
      logic [1:0] w;
      logic [1:0] h;
      int         reps;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   rec_t exp_q[$];
   int   m_cnt[NUM_CH][4];
   rec_t cur_rec;
   rec_t prev_rec;
   rec_t exp_rec;
   logic prev_stall = 1'b0;

   always #5 clk = ~clk;

   cache_stats_counter_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   cache_stats_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_ev(input logic [1:0] v, input logic [1:0] w, input logic [1:0] h);
      for (int c = 0; c < NUM_CH; c++) begin
         if (v[c]) begin
            if (w[c]) m_cnt[c][1] = (m_cnt[c][1] < MAXV) ? m_cnt[c][1] + 1 : MAXV;
            else      m_cnt[c][0] = (m_cnt[c][0] < MAXV) ? m_cnt[c][0] + 1 : MAXV;
            if (h[c]) m_cnt[c][2] = (m_cnt[c][2] < MAXV) ? m_cnt[c][2] + 1 : MAXV;
            else      m_cnt[c][3] = (m_cnt[c][3] < MAXV) ? m_cnt[c][3] + 1 : MAXV;
         end
      end
   endfunction

   function automatic void model_zero();
      for (int c = 0; c < NUM_CH; c++)
         for (int s = 0; s < 4; s++)
            m_cnt[c][s] = 0;
   endfunction

   function automatic void push_model();
      rec_t r;
      int   sum;
      for (int c = 0; c <= NUM_CH; c++) begin
         for (int s = 0; s < 4; s++) begin
            sum = 0;
            if (c < NUM_CH) sum = m_cnt[c][s];
            else for (int k = 0; k < NUM_CH; k++) sum += m_cnt[k][s];
            r.ch   = 2'(c);
            r.sel  = 2'(s);
            r.data = CNT_W'((sum > MAXV) ? MAXV : sum);
            r.last = (c == NUM_CH) && (s == 3);
            exp_q.push_back(r);
         end
      end
   endfunction

   task automatic ev(input logic [1:0] v, input logic [1:0] w, input logic [1:0] h);
      bus.acc_valid = v;
      bus.acc_write = w;
      bus.acc_hit   = h;
      tick();
      model_ev(v, w, h);
      bus.acc_valid = '0;
      bus.acc_write = '0;
      bus.acc_hit   = '0;
   endtask

   // Expectations must be queued before the call; the dump_req cycle can also carry events/clear
   task automatic do_dump(input logic [1:0] v, input logic [1:0] w, input logic [1:0] h,
                          input logic clr, input int mode, input int pulse_at, input int exp_cycles);
      int n;
      bus.acc_valid = v;
      bus.acc_write = w;
      bus.acc_hit   = h;
      bus.clear     = clr;
      bus.dump_req  = 1'b1;
      tick();
      if (clr) model_zero();
      else     model_ev(v, w, h);
      bus.acc_valid = '0;
      bus.acc_write = '0;
      bus.acc_hit   = '0;
      bus.clear     = 1'b0;
      bus.dump_req  = 1'b0;
      chk("first_record_valid", bus.out_valid, 1);
      n = 0;
      while (bus.dump_busy && n < 100) begin
         bus.out_ready = (mode == 0) ? 1'b1 : n[0];
         bus.dump_req  = (n == pulse_at);
         tick();
         n++;
      end
      bus.dump_req  = 1'b0;
      bus.out_ready = 1'b1;
      chk("dump_cycles", n, exp_cycles);
      chk("dump_drained", exp_q.size(), 0);
      chk("valid_after_last", bus.out_valid, 0);
   endtask

   always @(negedge clk) begin
      cur_rec = {bus.out_ch, bus.out_sel, bus.out_data, bus.out_last};
      if (!bus.out_valid) chk("idle_outputs_zero", cur_rec, 0);
      if (prev_stall && bus.out_valid) chk("stall_hold", cur_rec, prev_rec);
      if (bus.out_valid && bus.out_ready) begin
         chk("record_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            exp_rec = exp_q.pop_front();
            chk("record", cur_rec, exp_rec);
         end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_rec   = cur_rec;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ev_t vecs[3];
      int  exp_tab[NREC];
      rec_t r;
      int  n;

      vecs[0] = '{v: 2'b01, w: 2'b00, h: 2'b01, reps: 3};
      vecs[1] = '{v: 2'b01, w: 2'b01, h: 2'b00, reps: 1};
      vecs[2] = '{v: 2'b10, w: 2'b00, h: 2'b00, reps: 2};
      exp_tab = '{3, 1, 3, 1, 2, 0, 0, 2, 5, 1, 3, 3};

      bus.acc_valid = '0;
      bus.acc_write = '0;
      bus.acc_hit   = '0;
      bus.clear     = 1'b0;
      bus.dump_req  = 1'b0;
      bus.out_ready = 1'b1;
      model_zero();

      #12;
      chk("reset_valid", bus.out_valid, 0);
      chk("reset_busy", bus.dump_busy, 0);
      chk("reset_data", bus.out_data, 0);
      tick();
      rst = 1'b0;

      for (int i = 0; i < 3; i++)
         for (int k = 0; k < vecs[i].reps; k++)
            ev(vecs[i].v, vecs[i].w, vecs[i].h);
      for (int i = 0; i < NREC; i++) begin
         r.ch   = 2'(i / 4);
         r.sel  = 2'(i % 4);
         r.data = CNT_W'(exp_tab[i]);
         r.last = (i == NREC - 1);
         exp_q.push_back(r);
      end
      do_dump(2'b00, 2'b00, 2'b00, 1'b0, 0, -1, NREC);

      // Clear with simultaneous events: events must be dropped
      bus.clear     = 1'b1;
      bus.acc_valid = 2'b11;
      bus.acc_hit   = 2'b11;
      tick();
      model_zero();
      bus.clear     = 1'b0;
      bus.acc_valid = '0;
      bus.acc_hit   = '0;

      for (int i = 0; i < 300; i++)
         ev((i < 20) ? 2'b11 : 2'b01, 2'b00, 2'b11);
      push_model();
      do_dump(2'b00, 2'b00, 2'b00, 1'b0, 0, -1, NREC);

      ev(2'b10, 2'b10, 2'b00);
      ev(2'b11, 2'b01, 2'b10);
      push_model();
      do_dump(2'b00, 2'b00, 2'b00, 1'b0, 1, -1, 2 * NREC);

      push_model();
      do_dump(2'b11, 2'b00, 2'b11, 1'b1, 0, 3, NREC);
      repeat (3) tick();
      chk("no_requeued_dump", bus.dump_busy, 0);
      ev(2'b01, 2'b01, 2'b01);
      ev(2'b01, 2'b01, 2'b01);
      push_model();
      do_dump(2'b00, 2'b00, 2'b00, 1'b0, 0, -1, NREC);

      ev(2'b11, 2'b00, 2'b00);
      push_model();
      bus.dump_req = 1'b1;
      tick();
      bus.dump_req = 1'b0;
      n = 0;
      while (exp_q.size() > NREC - 5 && n < 50) begin
         tick();
         n++;
      end
      chk("five_records", exp_q.size(), NREC - 5);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", bus.out_valid, 0);
      chk("rst_async_busy", bus.dump_busy, 0);
      chk("rst_async_data", bus.out_data, 0);
      exp_q.delete();
      model_zero();
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("no_resume_after_rst", bus.dump_busy, 0);
      push_model();
      do_dump(2'b00, 2'b00, 2'b00, 1'b0, 0, -1, NREC);

      ev(2'b01, 2'b00, 2'b01);
      push_model();
      do_dump(2'b11, 2'b10, 2'b01, 1'b0, 0, -1, NREC);
      push_model();
      do_dump(2'b00, 2'b00, 2'b00, 1'b0, 0, -1, NREC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
